// File: rtl/spinner_ctrl.sv
// spinner_ctrl
//   Produces a 0..5 spinner position for the 7-segment spinner decoder.
//   The position advances at a programmable rate. Rate and direction come
//   from asynchronous push buttons. Run/pause is an asynchronous level.
//
//   Ports
//     clk_i      system clock
//     rst_ni     asynchronous active-low reset
//     run_i      level: 1 = spin, 0 = freeze position and divider
//     faster_i   button: each rising edge raises speed by 1 (saturates at 7)
//     slower_i   button: each rising edge lowers speed by 1 (saturates at 0)
//     dir_tog_i  button: each rising edge toggles direction
//     pos_o      spinner position, always 0..5
//     speed_o    current speed level 0..7
//     dir_o      0 = incrementing, 1 = decrementing
//     step_o     1-cycle pulse in the cycle pos_o first shows a new value

// Per-input conditioning cell: 2-flop synchroniser, previous-value flop and
// a registered rising-edge pulse. The edge is masked until arm_i is set, so
// a button that is already high when reset releases cannot fire.
module spinner_btn_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic arm_i,
  input  logic d_i,
  output logic sync_o,
  output logic rise_o
);
  logic s1_q, s2_q, s3_q, rise_q;
  logic rise_d;

  always_comb begin
    rise_d = arm_i & s2_q & ~s3_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      s3_q   <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      s1_q   <= d_i;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      rise_q <= rise_d;
    end
  end

  assign sync_o = s2_q;
  assign rise_o = rise_q;
endmodule

module spinner_ctrl #(
  parameter logic [23:0] BASE_DIV   = 24'd1_000_000,
  parameter int          DIV_W      = 27,
  parameter logic [2:0]  SPEED_INIT = 3'd3
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       run_i,
  input  logic       faster_i,
  input  logic       slower_i,
  input  logic       dir_tog_i,
  output logic [2:0] pos_o,
  output logic [2:0] speed_o,
  output logic       dir_o,
  output logic       step_o
);
  localparam int NUM_IN = 4;
  localparam int I_RUN  = 0;
  localparam int I_FAST = 1;
  localparam int I_SLOW = 2;
  localparam int I_DIR  = 3;

  logic [NUM_IN-1:0] btn_in, btn_sync, btn_rise;
  logic [NUM_IN-1:0] unused_bits;

  // Counts the first three edges after reset so the previous-value flops
  // hold real synchronised data before edge detection is enabled.
  logic [1:0] arm_cnt_q, arm_cnt_d;
  logic       armed;

  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] base_w, limit, limit_m1;
  logic [2:0]       pos_q, pos_d, pos_next;
  logic [2:0]       speed_q, speed_d;
  logic             dir_q, dir_d;
  logic             step_q, step_d;
  logic             speed_chg;
  logic             run_s, fast_ev, slow_ev, dir_ev;

  assign btn_in = {dir_tog_i, slower_i, faster_i, run_i};

  spinner_btn_sync u_sync [NUM_IN-1:0] (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .arm_i  (armed),
    .d_i    (btn_in),
    .sync_o (btn_sync),
    .rise_o (btn_rise)
  );

  // run is a level (no edge needed); buttons only need their edge pulse.
  assign unused_bits = {btn_sync[I_DIR], btn_sync[I_SLOW], btn_sync[I_FAST], btn_rise[I_RUN]};

  assign run_s   = btn_sync[I_RUN];
  assign fast_ev = btn_rise[I_FAST];
  assign slow_ev = btn_rise[I_SLOW];
  assign dir_ev  = btn_rise[I_DIR];
  assign armed   = (arm_cnt_q == 2'd3);

  assign base_w   = DIV_W'(BASE_DIV);
  assign limit    = base_w * DIV_W'(4'd8 - {1'b0, speed_q});
  assign limit_m1 = limit - DIV_W'(1);

  always_comb begin
    arm_cnt_d = armed ? arm_cnt_q : arm_cnt_q + 2'd1;

    // Opposing requests in the same cycle cancel; saturated requests are
    // not a change and leave the divider alone.
    speed_d   = speed_q;
    speed_chg = 1'b0;
    if (fast_ev && !slow_ev && speed_q != 3'd7) begin
      speed_d   = speed_q + 3'd1;
      speed_chg = 1'b1;
    end else if (slow_ev && !fast_ev && speed_q != 3'd0) begin
      speed_d   = speed_q - 3'd1;
      speed_chg = 1'b1;
    end

    // Step direction uses the current dir_q; a toggle in this cycle only
    // affects later steps.
    if (dir_q) pos_next = (pos_q == 3'd0) ? 3'd5 : pos_q - 3'd1;
    else       pos_next = (pos_q >= 3'd5) ? 3'd0 : pos_q + 3'd1;

    dir_d  = dir_q ^ dir_ev;
    div_d  = div_q;
    pos_d  = pos_q;
    step_d = 1'b0;
    if (speed_chg) begin
      div_d = '0;                  // speed change beats a coincident step
    end else if (run_s) begin
      if (div_q == limit_m1) begin
        div_d  = '0;
        pos_d  = pos_next;
        step_d = 1'b1;
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      arm_cnt_q <= 2'd0;
      div_q     <= '0;
      pos_q     <= 3'd0;
      speed_q   <= SPEED_INIT;
      dir_q     <= 1'b0;
      step_q    <= 1'b0;
    end else begin
      arm_cnt_q <= arm_cnt_d;
      div_q     <= div_d;
      pos_q     <= pos_d;
      speed_q   <= speed_d;
      dir_q     <= dir_d;
      step_q    <= step_d;
    end
  end

  assign pos_o   = pos_q;
  assign speed_o = speed_q;
  assign dir_o   = dir_q;
  assign step_o  = step_q;
endmodule

// File: tb/tb_spinner_ctrl.sv
// Directed bench for spinner_ctrl with BASE_DIV=2, SPEED_INIT=7, DIV_W=8,
// so the step period is 2*(8-speed) cycles.
module tb_spinner_ctrl;
  logic       clk = 1'b0;
  logic       rst_ni = 1'b0;
  logic       run_i = 1'b1;
  logic       faster_i = 1'b0;
  logic       slower_i = 1'b0;
  logic       dir_tog_i = 1'b0;
  logic [2:0] pos_o, speed_o;
  logic       dir_o, step_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  spinner_ctrl #(
    .BASE_DIV   (24'd2),
    .DIV_W      (8),
    .SPEED_INIT (3'd7)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_ni),
    .run_i     (run_i),
    .faster_i  (faster_i),
    .slower_i  (slower_i),
    .dir_tog_i (dir_tog_i),
    .pos_o     (pos_o),
    .speed_o   (speed_o),
    .dir_o     (dir_o),
    .step_o    (step_o)
  );

  typedef struct {
    string name;
    int    n_fast;
    int    n_slow;
    int    n_both;
    int    hold_fast;
    int    exp_speed;
    int    exp_period;
  } spd_vec_t;

  spd_vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Waits for the next step_o pulse; returns the new position and the
  // number of cycles waited. A missing pulse counts as a failed comparison.
  task automatic wait_step(output int pos, output int cyc);
    cyc = 0;
    pos = -1;
    repeat (200) begin
      tick();
      cyc++;
      if (step_o === 1'b1) begin
        pos = int'(pos_o);
        return;
      end
    end
    n_tests++;
    n_fail++;
    $display("FAIL step_timeout: no step_o within %0d cycles", cyc);
  endtask

  // which: 0 = faster, 1 = slower, 2 = both together
  task automatic press(input int which, input int hi);
    if (which != 1) faster_i = 1'b1;
    if (which != 0) slower_i = 1'b1;
    repeat (hi) tick();
    faster_i = 1'b0;
    slower_i = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    int p, c, p0, bad_step, bad_pos;
    int seq1[7];
    int seq2[7];
    seq1 = '{1, 2, 3, 4, 5, 0, 1};
    seq2 = '{2, 3, 2, 1, 0, 5, 4};
    vecs[0] = '{"slow3",   0, 3,  0, 0,  4, 8};
    vecs[1] = '{"both",    0, 0,  1, 0,  4, 8};
    vecs[2] = '{"slow10",  0, 10, 0, 0,  0, 16};
    vecs[3] = '{"hold50",  0, 0,  0, 50, 1, 14};
    vecs[4] = '{"fast7",   7, 0,  0, 0,  7, 2};
    vecs[5] = '{"slow3b",  0, 3,  0, 0,  4, 8};

    // Reset state
    repeat (3) tick();
    check("rst_pos",   pos_o,   0);
    check("rst_speed", speed_o, 7);
    check("rst_dir",   dir_o,   0);
    check("rst_step",  step_o,  0);

    // 1: spin from reset, period 2
    @(posedge clk); #3; rst_ni = 1'b1;
    #3;
    check("t1_pos0", pos_o, 0);
    for (int i = 0; i < 7; i++) begin
      wait_step(p, c);
      check($sformatf("t1_pos%0d", i + 1), p, seq1[i]);
      if (i > 0) check($sformatf("t1_period%0d", i), c, 2);
    end

    // 2: dir press right after pos 1 appears; toggle lands on the step that
    // shows 3, which still uses the old direction.
    dir_tog_i = 1'b1;
    check("t2_dir_before", dir_o, 0);
    for (int i = 0; i < 7; i++) begin
      wait_step(p, c);
      if (i == 0) dir_tog_i = 1'b0;
      check($sformatf("t2_pos%0d", i), p, seq2[i]);
      check($sformatf("t2_period%0d", i), c, 2);
      if (i == 1) check("t2_dir_after", dir_o, 1);
    end

    // 3/4: speed table
    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < vecs[i].n_fast; j++) press(0, 3);
      for (int j = 0; j < vecs[i].n_slow; j++) press(1, 3);
      for (int j = 0; j < vecs[i].n_both; j++) press(2, 3);
      if (vecs[i].hold_fast > 0) press(0, vecs[i].hold_fast);
      repeat (4) tick();
      check({vecs[i].name, "_speed"}, speed_o, vecs[i].exp_speed);
      wait_step(p, c);
      wait_step(p, c);
      check({vecs[i].name, "_period"}, c, vecs[i].exp_period);
    end

    // 5: pause 3 cycles into an 8-cycle period. Two more counts slip
    // through the synchroniser, leaving 3; resume adds 2 cycles of sync.
    p0 = p;
    repeat (3) tick();
    run_i = 1'b0;
    bad_step = 0;
    bad_pos  = 0;
    repeat (20) begin
      tick();
      if (step_o !== 1'b0) bad_step++;
      if (int'(pos_o) != p0) bad_pos++;
    end
    check("t5_no_step", bad_step, 0);
    check("t5_frozen",  bad_pos,  0);
    run_i = 1'b1;
    wait_step(p, c);
    check("t5_resume_wait", c, 5);
    check("t5_resume_pos",  p, (p0 + 5) % 6);

    // 6: async reset between edges, with slower_i held across release
    repeat (2) tick();
    #2;
    rst_ni = 1'b0;
    #1;
    check("t6_pos",   pos_o,   0);
    check("t6_speed", speed_o, 7);
    check("t6_dir",   dir_o,   0);
    check("t6_step",  step_o,  0);
    slower_i = 1'b1;
    repeat (2) tick();
    @(posedge clk); #3; rst_ni = 1'b1;
    for (int i = 0; i < 7; i++) begin
      wait_step(p, c);
      check($sformatf("t6_pos%0d", i + 1), p, seq1[i]);
      if (i > 0) check($sformatf("t6_period%0d", i), c, 2);
    end
    check("t6_held_btn_speed", speed_o, 7);
    slower_i = 1'b0;
    repeat (5) tick();
    check("t6_release_speed", speed_o, 7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
